// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage core: load-use bubbles, branch squashes, memory waits, watchdog halt.
// Optional performance counters are built when HAZARD_PERF_CNT_EN is defined.
module pipeline_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_rs1_used,
  input  logic             id_rs2_used,
  input  logic             id_ex_mem_read,
  input  logic [4:0]       id_ex_rd,
  input  logic             ex_branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             id_ex_write,
  output logic             ex_mem_write,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             mem_wb_flush,
  output logic             pc_sel_branch,
`ifdef HAZARD_PERF_CNT_EN
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events,
`endif
  output logic             halted
);

  localparam logic [1:0] RUN      = 2'd0;
  localparam logic [1:0] MEM_WAIT = 2'd1;
  localparam logic [1:0] HALT     = 2'd2;

  localparam logic [7:0] TIMEOUT_CNT = 8'(MEM_TIMEOUT);

  logic [1:0] state_reg;
  logic [1:0] state_next;
  logic [7:0] wait_cnt_reg;
  logic [7:0] wait_cnt_next;

  logic mem_stall;
  logic rs1_hit;
  logic rs2_hit;
  logic load_use;
  logic active;

  assign mem_stall = mem_req & ~mem_ready;
  assign rs1_hit   = id_rs1_used & (id_rs1 == id_ex_rd);
  assign rs2_hit   = id_rs2_used & (id_rs2 == id_ex_rd);
  assign load_use  = id_ex_mem_read & (id_ex_rd != 5'd0) & (rs1_hit | rs2_hit);
  assign active    = ~reset & (state_reg != HALT);

  // Control outputs: reset forces bubbles everywhere, HALT freezes without flushing.
  always_comb begin
    pc_write      = 1'b1;
    if_id_write   = 1'b1;
    id_ex_write   = 1'b1;
    ex_mem_write  = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_flush   = 1'b0;
    mem_wb_flush  = 1'b0;
    pc_sel_branch = 1'b0;
    halted        = 1'b0;
    if (reset) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_write  = 1'b0;
      ex_mem_write = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      mem_wb_flush = 1'b1;
    end else if (state_reg == HALT) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_write  = 1'b0;
      ex_mem_write = 1'b0;
      halted       = 1'b1;
    end else if (mem_stall) begin
      // EX instruction is held, so a pending branch re-presents once memory releases.
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_write  = 1'b0;
      ex_mem_write = 1'b0;
      mem_wb_flush = 1'b1;
    end else if (ex_branch_taken) begin
      pc_sel_branch = 1'b1;
      if_id_flush   = 1'b1;
      id_ex_flush   = 1'b1;
    end else if (load_use) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      id_ex_flush = 1'b1;
    end
  end

  always_comb begin
    state_next    = state_reg;
    wait_cnt_next = wait_cnt_reg;
    case (state_reg)
      RUN: begin
        if (mem_stall) begin
          state_next    = MEM_WAIT;
          wait_cnt_next = 8'd1;
        end
      end
      MEM_WAIT: begin
        if (!mem_stall) begin
          state_next    = RUN;
          wait_cnt_next = 8'd0;
        end else if (wait_cnt_reg == TIMEOUT_CNT) begin
          state_next = HALT;
        end else begin
          wait_cnt_next = wait_cnt_reg + 8'd1;
        end
      end
      HALT: begin
        state_next = HALT;
      end
      default: begin
        state_next    = RUN;
        wait_cnt_next = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= RUN;
      wait_cnt_reg <= 8'd0;
    end else begin
      state_reg    <= state_next;
      wait_cnt_reg <= wait_cnt_next;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cycles_reg;
  logic [CNT_W-1:0] flush_events_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cycles_reg <= '0;
      flush_events_reg <= '0;
    end else begin
      if (active && (mem_stall || load_use))
        stall_cycles_reg <= stall_cycles_reg + CNT_W'(1);
      if (pc_sel_branch)
        flush_events_reg <= flush_events_reg + CNT_W'(1);
    end
  end

  // Counters read as zero for the whole reset window, including its first cycle.
  assign stall_cycles = reset ? '0 : stall_cycles_reg;
  assign flush_events = reset ? '0 : flush_events_reg;
`else
  logic unused_active;
  assign unused_active = active;
`endif

endmodule
